clk_div_bank: RTL and testbench

Multi-channel, run-time programmable clock-enable/clock divider; the next generation of the team's fixed divide-by-4 (100 MHz → 25 MHz) divider. Each channel produces a 50 % duty square wave at clk / (2·(div+1)) plus a one-cycle rising-edge tick. Divide values are reloaded glitch-free, and all channels can be phase-aligned. It sits next to the 100 MHz system clock and feeds slow peripherals (VGA pixel timing, UART/SPI baud, LED scan).

---
 rtl/clk_div_bank.sv | 87 ++++++++
 tb/tb_clk_div_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Multi-channel programmable 50 % duty clock divider with tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_bank #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [CHANNELS-1:0]                             en,
  input  logic                                            div_load,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] div_ch,
  input  logic [CNT_W-1:0]                                div_val,
  input  logic                                            sync,
  output logic [CHANNELS-1:0]                             divided_clk,
  output logic [CHANNELS-1:0]                             tick
);

  localparam int             c_CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             w_hit;
    logic             w_wrap;

    // Out-of-range div_ch matches no channel, so such loads vanish.
    assign w_hit  = div_load && (div_ch == c_CH_W'(i));
    assign w_wrap = (cnt_q == active_q);

    always_comb begin
      shadow_d = w_hit ? div_val : shadow_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      if (sync) begin
        // A load in the sync cycle is taken straight into active.
        cnt_d    = '0;
        clk_d    = 1'b0;
        active_d = shadow_d;
      end else if (!en[i]) begin
        cnt_d    = '0;
        clk_d    = 1'b0;
        active_d = shadow_q;
      end else if (w_wrap) begin
        cnt_d    = '0;
        clk_d    = ~clk_q;
        tick_d   = ~clk_q;
        active_d = shadow_q;
      end else begin
        cnt_d    = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        shadow_q <= c_DEF_DIV;
        active_q <= c_DEF_DIV;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign divided_clk[i] = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// Module   : tb_clk_div_bank
// Purpose  : Self-checking bench for clk_div_bank (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        div_load;
  logic [0:0]  div_ch;
  logic [15:0] div_val;
  logic        sync;
  logic [1:0]  divided_clk, tick;

  logic [2:0]  en3;
  logic        ld3;
  logic [1:0]  ch3;
  logic [15:0] val3;
  logic [2:0]  dc3, tk3;

  always #5 clk = ~clk;

  clk_div_bank #(.CHANNELS(2), .CNT_W(16), .DEFAULT_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_load(div_load), .div_ch(div_ch),
    .div_val(div_val), .sync(sync), .divided_clk(divided_clk), .tick(tick)
  );

  clk_div_bank #(.CHANNELS(3), .CNT_W(16), .DEFAULT_DIV(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .div_load(ld3), .div_ch(ch3),
    .div_val(val3), .sync(1'b0), .divided_clk(dc3), .tick(tk3)
  );

  typedef struct {
    logic [1:0]  en;
    logic        ld;
    logic        ch;
    logic [15:0] val;
    logic        sy;
    logic [1:0]  dc;
    logic [1:0]  tk;
  } vec_t;

  typedef struct {
    logic [5:0] want;
    string      nm;
  } sb_t;

  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[8];

  // Ideal divider output k edges after enable: rises at k=d, period 2(d+1).
  function automatic logic [1:0] wave(input int k, input int d);
    int p;
    if (k < d) return 2'b00;
    p = (k - d) % (2 * d + 2);
    return {p <= d, p == 0};
  endfunction

  function automatic vec_t mk(input logic [1:0] en_v, input logic ld_v, input logic ch_v,
                              input logic [15:0] val_v, input logic sy_v,
                              input logic [1:0] w0, input logic [1:0] w1);
    vec_t v;
    v.en = en_v; v.ld = ld_v; v.ch = ch_v; v.val = val_v; v.sy = sy_v;
    v.dc = {w1[1], w0[1]};
    v.tk = {w1[0], w0[0]};
    return v;
  endfunction

  task automatic chk_now(input logic [5:0] got, input logic [5:0] want, input string nm);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b required %b", nm, got, want);
    end
  endtask

  task automatic expect_after_edge(input logic [5:0] want, input string nm, input bit sel3);
    sb_t e;
    sb_q.push_back('{want, nm});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_now(sel3 ? {dc3, tk3} : {2'b00, divided_clk, tick}, e.want, e.nm);
  endtask

  task automatic apply(input vec_t v, input string nm);
    en = v.en; div_load = v.ld; div_ch = v.ch; div_val = v.val; sync = v.sy;
    expect_after_edge({2'b00, v.dc, v.tk}, nm, 1'b0);
  endtask

  task automatic apply3(input logic [2:0] e, input logic ld, input logic [1:0] ch,
                        input logic [15:0] val, input logic [2:0] dc, input logic [2:0] tk,
                        input string nm);
    en3 = e; ld3 = ld; ch3 = ch; val3 = val;
    expect_after_edge({dc, tk}, nm, 1'b1);
  endtask

  initial begin
    logic [1:0] w0, w1, w2;

    tbl[0] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[1] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b11};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b00};
    tbl[3] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[5] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b11};
    tbl[6] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b00};
    tbl[7] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};

    rst_n = 1'b0; en = '0; div_load = 1'b0; div_ch = '0; div_val = '0; sync = 1'b0;
    en3 = '0; ld3 = 1'b0; ch3 = '0; val3 = '0;
    #13;
    chk_now({divided_clk, tick}, 6'd0, "reset_main");
    chk_now({dc3, tk3}, 6'd0, "reset_3ch");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default divide, both channels.
    foreach (tbl[i]) apply(tbl[i], $sformatf("default_div k=%0d", i));

    // Out-of-range load on the 3-channel instance, then a real load on ch2.
    apply3(3'b000, 1'b1, 2'd3, 16'd5, 3'b000, 3'b000, "oor_load");
    apply3(3'b000, 1'b1, 2'd2, 16'd2, 3'b000, 3'b000, "ch2_load");
    apply3(3'b000, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, "ch3_idle");
    for (int k = 0; k < 12; k++) begin
      w0 = wave(k, 1); w2 = wave(k, 2);
      apply3(3'b111, 1'b0, 2'd0, 16'd0, {w2[1], w0[1], w0[1]}, {w2[0], w0[0], w0[0]},
             $sformatf("oor_run k=%0d", k));
    end
    apply3(3'b000, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, "ch3_stop");

    // Idle load of ch1 = 4.
    apply(mk(2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00), "stop");
    apply(mk(2'b00, 1'b1, 1'b1, 16'd4, 1'b0, 2'b00, 2'b00), "idle_load_ch1");
    apply(mk(2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00), "idle");
    for (int k = 0; k < 24; k++)
      apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b0, wave(k, 1), wave(k, 4)),
            $sformatf("div4_ch1 k=%0d", k));

    // Ch0 at div 7, reloaded to 1 in the middle of the high phase.
    apply(mk(2'b00, 1'b1, 1'b0, 16'd7, 1'b0, 2'b00, 2'b00), "load_ch0_7");
    apply(mk(2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00), "idle");
    for (int k = 0; k < 27; k++) begin
      w0 = (k < 15) ? wave(k, 7) : {((k - 15) % 4) >= 2, ((k - 15) % 4) == 2};
      apply(mk(2'b01, k == 10, 1'b0, 16'd1, 1'b0, w0, 2'b00), $sformatf("midhigh k=%0d", k));
    end

    // Ch0 div 3, load 0 exactly on a toggle edge.
    apply(mk(2'b00, 1'b1, 1'b0, 16'd3, 1'b0, 2'b00, 2'b00), "load_ch0_3");
    apply(mk(2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00), "idle");
    for (int k = 0; k < 17; k++) begin
      w0 = (k < 11) ? wave(k, 3) : {((k - 11) % 2) == 0, ((k - 11) % 2) == 0};
      apply(mk(2'b01, k == 7, 1'b0, 16'd0, 1'b0, w0, 2'b00), $sformatf("toggle_load k=%0d", k));
    end

    // Sync with ch0 div 1, ch1 div 3.
    apply(mk(2'b00, 1'b1, 1'b0, 16'd1, 1'b0, 2'b00, 2'b00), "load_ch0_1");
    apply(mk(2'b00, 1'b1, 1'b1, 16'd3, 1'b0, 2'b00, 2'b00), "load_ch1_3");
    apply(mk(2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00), "idle");
    for (int k = 0; k < 9; k++)
      apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b0, wave(k, 1), wave(k, 3)),
            $sformatf("presync k=%0d", k));
    apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00), "sync");
    for (int m = 1; m < 14; m++)
      apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b0, wave(m - 1, 1), wave(m - 1, 3)),
            $sformatf("postsync S+%0d", m));

    // Sync with a load in the same cycle: ch1 goes straight to div 0.
    apply(mk(2'b11, 1'b1, 1'b1, 16'd0, 1'b1, 2'b00, 2'b00), "sync_load");
    for (int m = 1; m < 7; m++)
      apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b0, wave(m - 1, 1), wave(m - 1, 0)),
            $sformatf("sync_load S+%0d", m));

    // Ch0 is high here; a short asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_now({divided_clk, tick}, 6'd0, "async_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      apply(mk(2'b11, 1'b0, 1'b0, 16'd0, 1'b0, wave(k, 1), wave(k, 1)),
            $sformatf("after_reset k=%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
